// File: rtl/nes_vga_pkg.sv
// Shared constants, fetch FSM encoding and NES 2C02 palette for the 2x line scaler.
// No ports; imported by nes_line_buffer and nes_line_scaler.
package nes_vga_pkg;

  localparam int unsigned H_ACT    = 640;
  localparam int unsigned V_ACT    = 480;
  localparam int unsigned NES_W    = 256;
  localparam int unsigned NES_H    = 240;
  localparam int unsigned X_BORDER = 64;
  localparam int unsigned PIPE_LAT = 3;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned COL_W    = 8;
  localparam int unsigned LINE_W   = 8;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned CH_W     = 10;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned LB_AW    = COL_W + 1;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_DONE = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  // Standard 2C02 palette, 8-bit RGB per entry
  localparam logic [23:0] NES_PALETTE [64] = '{
    24'h545454, 24'h001E74, 24'h081090, 24'h300088, 24'h440064, 24'h5C0030, 24'h540400, 24'h3C1800,
    24'h202A00, 24'h083A00, 24'h004000, 24'h003C00, 24'h00323C, 24'h000000, 24'h000000, 24'h000000,
    24'h989698, 24'h084CC4, 24'h3032EC, 24'h5C1EE4, 24'h8814B0, 24'hA01464, 24'h982220, 24'h783C00,
    24'h545A00, 24'h287200, 24'h087C00, 24'h007628, 24'h006678, 24'h000000, 24'h000000, 24'h000000,
    24'hECEEEC, 24'h4C9AEC, 24'h787CEC, 24'hB062EC, 24'hE454EC, 24'hEC58B4, 24'hEC6A64, 24'hD48820,
    24'hA0AA00, 24'h74C400, 24'h4CD020, 24'h38CC6C, 24'h38B4CC, 24'h3C3C3C, 24'h000000, 24'h000000,
    24'hECEEEC, 24'hA8CCEC, 24'hBCBCEC, 24'hD4B2EC, 24'hECAEEC, 24'hECAED4, 24'hECB4B0, 24'hE4C490,
    24'hCCD278, 24'hB4DE78, 24'hA8E290, 24'h98E2B4, 24'hA0D6E4, 24'hA0A2A0, 24'h000000, 24'h000000
  };

  // 8-bit palette channels widened to 10 bits by a left shift of 2
  function automatic rgb_t pal_lookup(input logic [IDX_W-1:0] idx);
    logic [23:0] c;
    rgb_t        o;
    c   = NES_PALETTE[idx];
    o.r = {c[23:16], 2'b00};
    o.g = {c[15:8],  2'b00};
    o.b = {c[7:0],   2'b00};
    return o;
  endfunction

endpackage

// File: rtl/nes_line_buffer.sv
// Ping-pong line buffer: 2 banks x 256 x 6-bit simple dual-port RAM.
// Ports: clk_i, rst_i (async, resets read register only), wr_en_i/wr_addr_i/wr_data_i
// write port, rd_addr_i in, rd_data_o registered read data.
module nes_line_buffer
  import nes_vga_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [LB_AW-1:0] wr_addr_i,
  input  logic [IDX_W-1:0] wr_data_i,
  input  logic [LB_AW-1:0] rd_addr_i,
  output logic [IDX_W-1:0] rd_data_o
);

  logic [IDX_W-1:0] mem_q [2*NES_W];
  logic [IDX_W-1:0] rd_data_q;

  // Storage array is deliberately not reset
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port (pipeline stage 2)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/nes_line_scaler.sv
// Scales a 256x240 NES frame to 640x480 (2x, letterboxed) from a ping-pong line buffer,
// refilling the idle bank one NES line ahead from a request/ack frame-buffer port.
// Ports: iCLK, iRST (async high); iCoord_X/iCoord_Y VGA active coordinates in;
// oRed/oGreen/oBlue pixel out (3-cycle latency); oMem_Req/oMem_Addr/iMem_Ack/iMem_Data
// frame-buffer read port; oUnderrun sticky fetch-late flag.
module nes_line_scaler
  import nes_vga_pkg::*;
(
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [COORD_W-1:0] iCoord_X,
  input  logic [COORD_W-1:0] iCoord_Y,
  output logic [CH_W-1:0]    oRed,
  output logic [CH_W-1:0]    oGreen,
  output logic [CH_W-1:0]    oBlue,
  output logic [ADDR_W-1:0]  oMem_Addr,
  output logic               oMem_Req,
  input  logic               iMem_Ack,
  input  logic [IDX_W-1:0]   iMem_Data,
  output logic               oUnderrun
);

  localparam int unsigned X_RIGHT = X_BORDER + 2 * NES_W;

  // ---------------- display pipeline ----------------
  logic              s1_bank_q, s1_bank_d;
  logic [COL_W-1:0]  s1_idx_q, s1_idx_d;
  logic              s1_border_q, s1_border_d;
  logic              s2_border_q;
  logic [IDX_W-1:0]  s2_pix;
  rgb_t              s3_rgb_q, s3_rgb_d;

  // Stage 1 decode: bank is nes_line[0] = Y[1]; index is (X-64)>>1
  always_comb begin
    s1_bank_d   = iCoord_Y[1];
    s1_idx_d    = COL_W'((iCoord_X - COORD_W'(X_BORDER)) >> 1);
    s1_border_d = (iCoord_X < COORD_W'(X_BORDER)) || (iCoord_X >= COORD_W'(X_RIGHT));
  end

  // Stage 3 palette lookup; border pixels forced black
  always_comb begin
    s3_rgb_d = s2_border_q ? '0 : pal_lookup(s2_pix);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s1_bank_q   <= 1'b0;
      s1_idx_q    <= '0;
      s1_border_q <= 1'b0;
      s2_border_q <= 1'b0;
      s3_rgb_q    <= '0;
    end else begin
      s1_bank_q   <= s1_bank_d;
      s1_idx_q    <= s1_idx_d;
      s1_border_q <= s1_border_d;
      s2_border_q <= s1_border_q;
      s3_rgb_q    <= s3_rgb_d;
    end
  end

  assign oRed   = s3_rgb_q.r;
  assign oGreen = s3_rgb_q.g;
  assign oBlue  = s3_rgb_q.b;

  // ---------------- fetch engine ----------------
  fetch_state_e       state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic               underrun_q, underrun_d;
  logic               mem_req_q, mem_req_d;
  logic               boot_q;
  logic [COORD_W-1:0] y_prev_q;
  logic               line_start_c;
  logic [LINE_W-1:0]  cur_line_c;
  logic [LINE_W-1:0]  next_line_c;
  logic               wr_en_c;

  // Line start on every change to an even row; target is the following NES line
  always_comb begin
    line_start_c = (iCoord_Y != y_prev_q) && !iCoord_Y[0];
    cur_line_c   = LINE_W'(iCoord_Y >> 1);
    next_line_c  = (cur_line_c == LINE_W'(NES_H - 1)) ? '0 : cur_line_c + LINE_W'(1);
  end

  // Fetch FSM next-state; an ack is always written to the current target, even on abort
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    line_d     = line_q;
    underrun_d = underrun_q;
    wr_en_c    = 1'b0;
    mem_req_d  = 1'b0;

    unique case (state_q)
      FETCH_IDLE: begin
        if (boot_q) begin
          state_d = FETCH_REQ;
          col_d   = '0;
          line_d  = '0;
        end else if (line_start_c) begin
          state_d = FETCH_REQ;
          col_d   = '0;
          line_d  = next_line_c;
        end
      end
      FETCH_REQ: begin
        wr_en_c = iMem_Ack;
        if (line_start_c) begin
          underrun_d = 1'b1;
          col_d      = '0;
          line_d     = next_line_c;
        end else if (iMem_Ack) begin
          if (col_q == COL_W'(NES_W - 1)) begin
            state_d = FETCH_DONE;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      FETCH_DONE: begin
        // A start landing in this single cycle is still honoured
        if (line_start_c) begin
          state_d = FETCH_REQ;
          col_d   = '0;
          line_d  = next_line_c;
        end else begin
          state_d = FETCH_IDLE;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase

    mem_req_d = (state_d == FETCH_REQ);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= FETCH_IDLE;
      col_q      <= '0;
      line_q     <= '0;
      underrun_q <= 1'b0;
      mem_req_q  <= 1'b0;
      boot_q     <= 1'b1;
      y_prev_q   <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      line_q     <= line_d;
      underrun_q <= underrun_d;
      mem_req_q  <= mem_req_d;
      boot_q     <= 1'b0;
      y_prev_q   <= iCoord_Y;
    end
  end

  assign oMem_Req  = mem_req_q;
  assign oMem_Addr = {line_q, col_q};
  assign oUnderrun = underrun_q;

  nes_line_buffer u_line_buffer (
    .clk_i     (iCLK),
    .rst_i     (iRST),
    .wr_en_i   (wr_en_c),
    .wr_addr_i ({line_q[0], col_q}),
    .wr_data_i (iMem_Data),
    .rd_addr_i ({s1_bank_q, s1_idx_q}),
    .rd_data_o (s2_pix)
  );

endmodule

// File: doc/nes_line_scaler.md
NES_LINE_SCALER -- requirements
Module: nes_line_scaler

Interface
REQ-001 iCLK  in  1  pixel clock (25.175 MHz); all state changes on its rising edge.
REQ-002 iRST  in  1  reset; asynchronous, active-high.
REQ-003 iCoord_X  in  10  active-pixel column from the VGA controller, 0..639; holds its last value through blanking.
REQ-004 iCoord_Y  in  10  active-pixel row from the VGA controller, 0..479; holds its last value through blanking.
REQ-005 oRed, oGreen, oBlue  out  10 each  pixel colour for the VGA controller.
REQ-006 oMem_Addr  out  16  frame-buffer word address = {nes_line[7:0], nes_x[7:0]}.
REQ-007 oMem_Req  out  1  read request; held high with oMem_Addr stable until acknowledged.
REQ-008 iMem_Ack  in  1  read acknowledge; iMem_Data is valid in the same cycle.
REQ-009 iMem_Data  in  6  NES palette index.
REQ-010 oUnderrun  out  1  sticky flag: a line fetch did not finish before its line was due for display.

Function
REQ-011 The block SHALL map the 256x240 NES frame to 640x480 at 2x scale: nes_x = (iCoord_X-64)>>1, nes_line = iCoord_Y>>1.
REQ-012 The block SHALL drive black (0,0,0) for iCoord_X<64 and iCoord_X>=576; these are the letterbox borders.
REQ-013 Colour output SHALL be a 3-stage pipeline with fixed latency of 3 cycles from iCoord_X/iCoord_Y to oRed/oGreen/oBlue:
  - stage 1: register bank select, buffer index and border flag;
  - stage 2: line-buffer read;
  - stage 3: registered palette lookup.
REQ-014 Pixel data SHALL come from a ping-pong line buffer of 2 banks x 256 x 6 bits; the display bank is nes_line[0].
REQ-015 A line start event SHALL fire when iCoord_Y differs from its registered previous value and the new value is even.
REQ-016 On a line start for NES line n, the fetch engine SHALL load NES line (n+1) mod 240 into bank ((n+1) mod 240)[0].
REQ-017 The fetch FSM SHALL have states IDLE, REQ and DONE.
  - IDLE->REQ on a line start; the column counter is cleared to 0.
  - In REQ, oMem_Req=1 and oMem_Addr={line, col}.
  - On iMem_Ack, iMem_Data is written to bank[col] and col increments.
  - On ack with col=255, REQ->DONE; DONE->IDLE in the next cycle.
REQ-018 If a line start occurs while in REQ, the block SHALL set oUnderrun, abandon the current fetch and restart in REQ for the new line with col=0.
REQ-019 A line start with no ack in progress SHALL never drop a write; an ack arriving in the same cycle as an abort SHALL still be written to the old target.
REQ-020 oMem_Addr SHALL change only when the FSM enters REQ or after an ack.
REQ-021 The palette SHALL map 64 entries to 10-bit R/G/B, using the standard NES 2C02 palette scaled as 8-bit<<2.
REQ-022 oUnderrun SHALL clear only on reset.

Reset
REQ-023 On iRST, the following SHALL be zero: oRed/oGreen/oBlue, oMem_Req, oMem_Addr, oUnderrun, all pipeline registers and the previous-Y register.
REQ-024 On the first clock after iRST deasserts, the FSM SHALL enter REQ to fetch NES line 0 into bank 0 without waiting for a line start.
REQ-025 Line-buffer contents are not reset; display is undefined until the first fetch completes.
REQ-026 iRST asserted mid-fetch SHALL drop oMem_Req asynchronously; no further buffer writes occur.

Structure
REQ-027 Package nes_vga_pkg SHALL hold:
  - constants H_ACT=640, V_ACT=480, NES_W=256, NES_H=240, X_BORDER=64, PIPE_LAT=3;
  - the fetch state enum;
  - the 64-entry palette constant.
REQ-028 The line buffer SHALL be a sub-module nes_line_buffer: 512x6 simple dual-port RAM, one write port and one registered read port.

Verification
REQ-029 Reset release with an ack every cycle -> 256 requests at addresses 0x0000..0x00FF, then oMem_Req=0; no underrun.
REQ-030 Frame-buffer pixel (line 10, x 5) = index 0x16, stepping iCoord_Y 20 then 21 with iCoord_X=74 or 75 -> the 0x16 palette colour appears exactly 3 cycles later on all four pixels.
REQ-031 iCoord_X=63 and iCoord_X=576 with non-zero memory data -> output 0 after 3 cycles; X=64 -> a non-zero palette colour.
REQ-032 iCoord_Y transition 477->478 -> fetch of line 0 (addresses 0x0000..) into bank 0; the next frame's row 0 displays line 0 data.
REQ-033 Ack held low so the fetch stalls at col=100, then the next even-Y event -> oUnderrun=1, the fetch restarts at the new line with col 0, and oUnderrun stays 1.
REQ-034 iRST pulsed while in REQ at col=50 -> oMem_Req=0 immediately; after release, a refetch of line 0 starts at 0x0000.
